// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared encodings for the SRAM port arbiter
package mem_bus_arbiter_pkg;

    localparam logic [1:0] MEMRW_IDLE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } arb_state_e;

    typedef enum logic {
        GRANT_IF,
        GRANT_MEM
    } grant_e;

    // Code 11 is reserved and behaves like idle.
    function automatic logic memrw_active(input logic [1:0] rw);
        return (rw == MEMRW_READ) || (rw == MEMRW_WRITE);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
// sram_wait_timer: loadable down-counter timing the strobe hold of one SRAM access
module sram_wait_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load on access entry, then count down and park at zero.
    always_comb begin
        cnt_d = load_i ? LOAD_VAL : (en_i && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one async SRAM port between instruction fetch and the MEM stage
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic [1:0]        mem_memrw,
    input  logic [ADDR_W-1:0] mem_memaddr,
    input  logic [DATA_W-1:0] mem_memdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              timer_load, timer_zero;
    logic              mem_pend, if_pend, in_access, in_done;

    sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .en_i   (in_access),
        .zero_o (timer_zero)
    );

    assign in_access = (state_q == ST_ACCESS);
    assign in_done   = (state_q == ST_DONE);
    assign mem_pend  = memrw_active(mem_memrw) && !mem_done_q;
    assign if_pend   = if_req && !if_done_q;

    // The requester being completed this cycle no longer holds the pipeline.
    assign stall_req = (mem_pend && !(in_done && grant_q == GRANT_MEM)) ||
                       (if_pend  && !(in_done && grant_q == GRANT_IF));

    assign sram_ce_n = !in_access;
    assign sram_oe_n = !(in_access && !write_q);
    assign sram_we_n = !(in_access && write_q);
    assign if_ready  = in_done && grant_q == GRANT_IF;
    assign mem_ready = in_done && grant_q == GRANT_MEM;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // Done flags remember served requesters until the pipeline advances.
    always_comb begin
        if_done_d  = stall_req && (if_done_q  || (in_done && grant_q == GRANT_IF));
        mem_done_d = stall_req && (mem_done_q || (in_done && grant_q == GRANT_MEM));
    end

    // Access sequencer: MEM wins over IF, operands latched on entry to ACCESS.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        timer_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_pend) begin
                    grant_d    = GRANT_MEM;
                    addr_d     = mem_memaddr;
                    wdata_d    = mem_memdata;
                    write_d    = (mem_memrw == MEMRW_WRITE);
                    timer_load = 1'b1;
                    state_d    = ST_ACCESS;
                end else if (if_pend) begin
                    grant_d    = GRANT_IF;
                    addr_d     = if_addr;
                    write_d    = 1'b0;
                    timer_load = 1'b1;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (timer_zero) begin
                    if (!write_q && grant_q == GRANT_MEM)
                        mem_rdata_d = sram_rdata;
                    if (!write_q && grant_q == GRANT_IF)
                        if_rdata_d = sram_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset drops any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GRANT_IF;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed checks of the SRAM arbiter against a transaction-level model
module tb_mem_bus_arbiter;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        if_req = 1'b0, mem_ready, if_ready, stall_req;
    logic [19:0] if_addr = '0, mem_memaddr = '0, sram_addr;
    logic [1:0]  mem_memrw = 2'b00;
    logic [31:0] mem_memdata = '0, if_rdata, mem_rdata, sram_wdata, sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    logic        if_req1 = 1'b0, mem_ready1, if_ready1, stall_req1;
    logic [19:0] if_addr1 = '0, sram_addr1;
    logic [31:0] if_rdata1, mem_rdata1, sram_wdata1, sram_rdata1;
    logic        ce1_n, oe1_n, we1_n;

    logic [31:0] sram_mem [0:255];
    logic [31:0] gold [0:255];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(W)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .mem_memrw(mem_memrw), .mem_memaddr(mem_memaddr),
        .mem_memdata(mem_memdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_req(stall_req), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    mem_bus_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
        .if_ready(if_ready1), .mem_memrw(2'b00), .mem_memaddr(20'h0),
        .mem_memdata(32'h0), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
        .stall_req(stall_req1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
        .sram_rdata(sram_rdata1), .sram_ce_n(ce1_n), .sram_oe_n(oe1_n), .sram_we_n(we1_n)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] v;
        v = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
        return (i == 16) ? 32'h1234_5678 : v;
    endfunction

    // Asynchronous SRAM: read data only while output-enabled, write while write-enabled.
    assign sram_rdata  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : '0;
    assign sram_rdata1 = (!ce1_n && !oe1_n) ? sram_mem[sram_addr1[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_init)
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
        else if (!sram_ce_n && !sram_we_n)
            sram_mem[sram_addr[7:0]] <= sram_wdata;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Transaction plan: ordered list of accesses the spec says will be served.
    int          n_acc, last_k;
    bit          a_mem [2];
    bit          a_wr  [2];
    logic [19:0] a_addr [2];
    logic [31:0] a_data [2];
    logic [19:0] s_if_addr, s_mem_addr;
    logic [31:0] s_mem_data;
    logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input bit do_if, input logic [19:0] ia, input logic [1:0] rw,
                         input logic [19:0] ma, input logic [31:0] md);
        if_req = do_if; if_addr = ia; mem_memrw = rw; mem_memaddr = ma; mem_memdata = md;
        s_if_addr = ia; s_mem_addr = ma; s_mem_data = md;
        n_acc = 0;
        if (rw inside {2'b01, 2'b10}) begin
            a_mem[0] = 1'b1; a_wr[0] = rw[1]; a_addr[0] = ma; a_data[0] = md; n_acc = 1;
        end
        if (do_if) begin
            a_mem[n_acc] = 1'b0; a_wr[n_acc] = 1'b0; a_addr[n_acc] = ia; a_data[n_acc] = '0;
            n_acc++;
        end
        last_k = (n_acc == 0) ? 2 : (n_acc - 1) * (W + 2) + W + 1;
    endtask

    // Cycle k counts from the IDLE cycle in which the requests first appear.
    task automatic observe(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            int  j, off;
            bit  in_acc, is_done, wr, m;
            if (k > k0) @(negedge clk);
            j = k / (W + 2);
            off = k % (W + 2);
            in_acc  = (j < n_acc) && off >= 1 && off <= W;
            is_done = (j < n_acc) && off == W + 1;
            wr = (j < n_acc) && a_wr[j];
            m  = (j < n_acc) && a_mem[j];
            if (is_done && !wr && m)  exp_mem_rdata = gold[a_addr[j][7:0]];
            if (is_done && !wr && !m) exp_if_rdata  = gold[a_addr[j][7:0]];
            if (is_done && wr)        gold[a_addr[j][7:0]] = a_data[j];
            chk($sformatf("stall k=%0d", k), stall_req, n_acc > 0 && k < last_k);
            chk($sformatf("ce_n k=%0d", k), sram_ce_n, !in_acc);
            chk($sformatf("oe_n k=%0d", k), sram_oe_n, !(in_acc && !wr));
            chk($sformatf("we_n k=%0d", k), sram_we_n, !(in_acc && wr));
            chk($sformatf("if_ready k=%0d", k), if_ready, is_done && !m);
            chk($sformatf("mem_ready k=%0d", k), mem_ready, is_done && m);
            chk($sformatf("if_rdata k=%0d", k), if_rdata, exp_if_rdata);
            chk($sformatf("mem_rdata k=%0d", k), mem_rdata, exp_mem_rdata);
            if (in_acc) chk($sformatf("sram_addr k=%0d", k), sram_addr, a_addr[j]);
            if (in_acc && wr) chk($sformatf("sram_wdata k=%0d", k), sram_wdata, a_data[j]);
            if (in_acc && off < W && m) begin
                mem_memaddr = 20'($urandom); mem_memdata = $urandom;
            end
            if (in_acc && off < W && !m) if_addr = 20'($urandom);
            if (in_acc && off == W) begin
                if_addr = s_if_addr; mem_memaddr = s_mem_addr; mem_memdata = s_mem_data;
            end
        end
    endtask

    task automatic run_txn(input bit do_if, input logic [19:0] ia, input logic [1:0] rw,
                           input logic [19:0] ma, input logic [31:0] md);
        @(posedge clk); #1;
        setup(do_if, ia, rw, ma, md);
        @(negedge clk);
        observe(0, last_k);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = init_word(i);
        repeat (2) @(negedge clk);
        chk("reset ce_n", sram_ce_n, 1'b1);
        chk("reset oe_n", sram_oe_n, 1'b1);
        chk("reset we_n", sram_we_n, 1'b1);
        chk("reset if_ready", if_ready, 1'b0);
        chk("reset mem_ready", mem_ready, 1'b0);
        chk("reset stall", stall_req, 1'b0);
        chk("reset if_rdata", if_rdata, 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset sram_addr", sram_addr, 20'h0);
        chk("reset sram_wdata", sram_wdata, 32'h0);
        rst = 1'b0; mem_init = 1'b0;

        run_txn(1'b1, 20'h00010, 2'b00, 20'h0, 32'h0);
        chk("fetch 0x10 data", if_rdata, 32'h1234_5678);
        run_txn(1'b0, 20'h0, 2'b10, 20'h00020, 32'hDEAD_BEEF);
        chk("write keeps mem_rdata", mem_rdata, 32'h0);
        run_txn(1'b0, 20'h0, 2'b01, 20'h00020, 32'h0);
        chk("readback 0x20", mem_rdata, 32'hDEAD_BEEF);
        run_txn(1'b1, 20'h00040, 2'b01, 20'h00030, 32'h0);
        run_txn(1'b0, 20'h0, 2'b11, 20'h00055, 32'h1);
        run_txn(1'b0, 20'h0, 2'b00, 20'h0, 32'h0);

        @(posedge clk); #1;
        setup(1'b1, 20'h00050, 2'b00, 20'h0, 32'h0);
        @(negedge clk);
        observe(0, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset ce_n", sram_ce_n, 1'b1);
        chk("midreset oe_n", sram_oe_n, 1'b1);
        chk("midreset we_n", sram_we_n, 1'b1);
        chk("midreset if_ready", if_ready, 1'b0);
        chk("midreset mem_ready", mem_ready, 1'b0);
        chk("midreset if_rdata", if_rdata, 32'h0);
        chk("midreset mem_rdata", mem_rdata, 32'h0);
        chk("midreset sram_addr", sram_addr, 20'h0);
        chk("midreset sram_wdata", sram_wdata, 32'h0);
        rst = 1'b0;
        exp_if_rdata = '0; exp_mem_rdata = '0;
        observe(0, last_k);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [1:0]  rw;
            kind = $urandom_range(0, 5);
            rw = (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : (kind == 3) ? 2'($urandom_range(1, 2)) :
                 (kind == 4) ? 2'b11 : 2'b00;
            run_txn(kind inside {0, 3, 4}, 20'($urandom_range(0, 255)), rw,
                    20'($urandom_range(0, 255)), $urandom);
        end
        @(posedge clk); #1;
        setup(1'b0, 20'h0, 2'b00, 20'h0, 32'h0);

        for (int f = 0; f < 4; f++) begin
            logic [19:0] a, prev;
            prev = sram_addr1;
            a = 20'($urandom_range(0, 255));
            @(posedge clk); #1;
            if_req1 = 1'b1; if_addr1 = a;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("w1 stall f=%0d k=%0d", f, k), stall_req1, k < 2);
                chk($sformatf("w1 ce_n f=%0d k=%0d", f, k), ce1_n, k != 1);
                chk($sformatf("w1 if_ready f=%0d k=%0d", f, k), if_ready1, k == 2);
                chk($sformatf("w1 sram_addr f=%0d k=%0d", f, k), sram_addr1, k == 0 ? prev : a);
                if (k == 2) chk($sformatf("w1 if_rdata f=%0d", f), if_rdata1, gold[a[7:0]]);
            end
        end
        @(posedge clk); #1;
        if_req1 = 1'b0;
        @(negedge clk);
        chk("w1 idle stall", stall_req1, 1'b0);
        chk("w1 idle ce_n", ce1_n, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates a single shared asynchronous SRAM port between the instruction-fetch stage and the MEM stage of the pipeline. The MEM-stage request comes straight from the EX/MEM pipeline register outputs (rw code, address, store data). The block sequences each SRAM access with a fixed wait-state count and returns read data with a one-cycle ready pulse. It raises a global stall request until every pending requester has been served, and holds the pipeline frozen meanwhile.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, cycles the SRAM strobes are held per access; legal range ≥1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid when if_ready=1, held afterwards
- if_ready  out  1  one-cycle pulse: fetch complete
- mem_memrw  in  2  MEM-stage op: 00 idle, 01 read, 10 write, 11 treated as idle
- mem_memaddr  in  ADDR_W  data address
- mem_memdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid when mem_ready=1 for a read, held afterwards
- mem_ready  out  1  one-cycle pulse: data access complete (read or write)
- stall_req  out  1  to pipeline control; freeze the IF..MEM stages while 1
- sram_addr  out  ADDR_W  registered address
- sram_wdata  out  DATA_W  registered write data
- sram_rdata  in  DATA_W  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes

## Operation
- Pending terms:
  - mem_pend = (mem_memrw is 01 or 10) && !mem_done
  - if_pend = if_req && !if_done
- States:
  - IDLE:
    - if mem_pend: latch mem addr/data/rw, grant=MEM, go ACCESS
    - else if if_pend: latch if_addr, grant=IF, go ACCESS
    - else stay
    - MEM has fixed priority over IF because it is the older instruction.
  - ACCESS:
    - Strobe levels: ce_n=0; read: oe_n=0, we_n=1; write: oe_n=1, we_n=0.
    - Wait counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
    - At 0: capture sram_rdata into the granted rdata register (reads only) and go DONE.
  - DONE:
    - All strobes high.
    - Pulse the granted ready.
    - Set mem_done or if_done.
    - Go IDLE.
- stall_req = mem_pend_eff || if_pend_eff (combinational), where:
  - *_pend_eff is the pending term with the granted requester treated as done in the DONE cycle.
- Done flags clear in any cycle where stall_req=0; the pipeline advances at that edge. Already-served requests held during a stall are therefore never re-issued.
- mem_rdata is unchanged by writes. sram_addr/sram_wdata hold their last value in IDLE/DONE.
- Reset (any state, including mid-ACCESS):
  - state=IDLE
  - strobes all 1
  - ready pulses 0
  - done flags 0
  - rdata regs, sram_addr, sram_wdata all 0
  - The aborted access is dropped, not resumed.

## Timing
- Request visible in IDLE at cycle t:
  - strobes active t+1..t+WAIT_CYCLES
  - ready pulse and valid rdata at t+WAIT_CYCLES+1 (DONE)
  - back in IDLE at t+WAIT_CYCLES+2
- Single requester: stall_req is 1 from t through t+WAIT_CYCLES and 0 in DONE, so the pipeline advances at the end of DONE.
- Both requesters pending at t:
  - MEM served first; stall_req stays 1 through its DONE.
  - IF enters ACCESS at t+WAIT_CYCLES+3.
  - if_ready at t+2·WAIT_CYCLES+3; stall_req drops in that cycle.
- Minimum one IDLE cycle between accesses; this guarantees we_n rises before the address changes.
- An input change during ACCESS has no effect (operands are latched).

## Structure
- Shared package holds:
  - MemRW encodings MEMRW_IDLE=2'b00, MEMRW_READ=2'b01, MEMRW_WRITE=2'b10
  - arbiter state enum (IDLE, ACCESS, DONE)
  - grant encoding (GRANT_IF, GRANT_MEM)
- One sub-module: sram_wait_timer.
  - Loadable down-counter, width $clog2(WAIT_CYCLES+1).
  - Inputs: load, en. Output: zero flag.
- Top level holds the FSM, operand/grant registers, done flags and strobe decode.

## Test plan
- WAIT_CYCLES=2, IF read addr 0x00010 (SRAM word 0x1234_5678) → if_ready pulse exactly 3 cycles after request, if_rdata=0x1234_5678, stall_req 1 for 3 cycles then 0.
- MEM write (10) addr 0x00020 data 0xDEAD_BEEF → we_n=0, oe_n=1 for 2 cycles with sram_wdata=0xDEAD_BEEF; mem_ready pulse; mem_rdata unchanged; a following MEM read of 0x00020 returns 0xDEAD_BEEF.
- Simultaneous MEM read 0x00030 and IF read 0x00040 → MEM strobes first and mem_ready at t+3; IF access after one IDLE, if_ready at t+7; stall_req continuous t..t+6, 0 at t+7; exactly two accesses issued.
- mem_memrw=11 with if_req=0 → no strobes, stall_req=0, state stays IDLE.
- rst=1 during 2nd ACCESS cycle → next edge: all strobes 1, ready 0, rdata 0, state IDLE; a request held after rst drops restarts from full WAIT_CYCLES.
- WAIT_CYCLES=1 build: back-to-back IF fetches, one per 3 cycles, each if_ready single-cycle, addresses updated only in ACCESS entry.
